// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-add multiplier control.
// Provides the control state encoding and the default operand width.
package mult_pkg;

  localparam int MULT_BITS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    HOLD  = 3'd4
  } mult_state_t;

endpackage

// File: rtl/mult_ctrl_fsm.sv
// Control sequencer for the 8-bit shift-add signed multiplier.
// In: Clk, Reset(n), Run, ClearA_LoadB, M. Out: Clr_AX, Ld_B, Ld_AX,
// Fn_Sub, Shift_En, Busy, Done (combinational decode of state/cnt/M).
module mult_ctrl_fsm
  import mult_pkg::*;
#(
  parameter int N_BITS = MULT_BITS
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic M,
  output logic Clr_AX,
  output logic Ld_B,
  output logic Ld_AX,
  output logic Fn_Sub,
  output logic Shift_En,
  output logic Busy,
  output logic Done
);

  localparam int CNT_W = $clog2(N_BITS);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(N_BITS - 1);

  mult_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last;

  assign last = (cnt_q == LAST);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    Clr_AX   = 1'b0;
    Ld_B     = 1'b0;
    Ld_AX    = 1'b0;
    Fn_Sub   = 1'b0;
    Shift_En = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    case (state_q)
      IDLE: begin
        // strobes fire even when Run wins the next state
        Clr_AX = ClearA_LoadB;
        Ld_B   = ClearA_LoadB;
        if (Run) state_d = CLR;
      end
      CLR: begin
        Clr_AX  = 1'b1;
        Busy    = 1'b1;
        cnt_d   = '0;
        state_d = ADD;
      end
      ADD: begin
        // last iteration weights the sign bit negatively
        Busy    = 1'b1;
        Ld_AX   = M;
        Fn_Sub  = last;
        state_d = SHIFT;
      end
      SHIFT: begin
        Busy     = 1'b1;
        Shift_En = 1'b1;
        if (last) begin
          state_d = HOLD;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = ADD;
        end
      end
      HOLD: begin
        // held Run must drop before a new start
        Done = 1'b1;
        if (!Run) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mult_ctrl_fsm.sv
// Scoreboard bench for mult_ctrl_fsm: a phase-level reference model
// predicts each cycle's outputs; a monitor compares at negedge.
module tb_mult_ctrl_fsm;

  localparam int N = 8;

  logic clk = 1'b0;
  logic Reset = 1'b0;
  logic Run = 1'b0;
  logic ClearA_LoadB = 1'b0;
  logic M = 1'b0;
  logic Clr_AX, Ld_B, Ld_AX, Fn_Sub;
  logic Shift_En, Busy, Done;

  mult_ctrl_fsm #(.N_BITS(N)) dut (
    .Clk         (clk),
    .Reset       (Reset),
    .Run         (Run),
    .ClearA_LoadB(ClearA_LoadB),
    .M           (M),
    .Clr_AX      (Clr_AX),
    .Ld_B        (Ld_B),
    .Ld_AX       (Ld_AX),
    .Fn_Sub      (Fn_Sub),
    .Shift_En    (Shift_En),
    .Busy        (Busy),
    .Done        (Done)
  );

  always #5 clk = ~clk;

  typedef enum int {P_IDLE, P_RUN, P_HOLD} phase_e;

  logic [6:0] exp_q[$];
  int         n_chk  = 0;
  int         n_fail = 0;
  int         cyc    = 0;
  int         s      = 0;
  bit         known  = 0;
  phase_e     ph     = P_IDLE;

  // vector order: {clr, ldb, ldax, fnsub, shift, busy, done}
  task automatic step(input logic run, input logic cl,
                      input logic m, input logic rst);
    logic [6:0] e;
    int d;
    @(posedge clk);
    #1;
    Run = run;
    ClearA_LoadB = cl;
    M = m;
    Reset = rst;
    e = '0;
    if (known) begin
      case (ph)
        P_IDLE: e = {cl, cl, 5'b0};
        P_RUN: begin
          d = cyc - s;
          if (d == 1)
            e = 7'b1000010;
          else if (d % 2 == 0)
            e = {2'b00, m,
                 ((d - 2) / 2 == N - 1) ? 1'b1 : 1'b0,
                 3'b010};
          else
            e = 7'b0000110;
        end
        default: e = 7'b0000001;
      endcase
      exp_q.push_back(e);
    end
    if (!rst) begin
      ph = P_IDLE;
      known = 1;
    end else if (known) begin
      case (ph)
        P_IDLE: if (run) begin ph = P_RUN; s = cyc; end
        P_RUN: if (cyc - s == 2 * N + 1) ph = P_HOLD;
        default: if (!run) ph = P_IDLE;
      endcase
    end
    cyc++;
  endtask

  always @(negedge clk) begin
    logic [6:0] e, a;
    int hot;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {Clr_AX, Ld_B, Ld_AX, Fn_Sub, Shift_En, Busy, Done};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs cyc=%0d got=%b want=%b",
                 cyc, a, e);
      end
      hot = int'(Clr_AX) + int'(Ld_AX) + int'(Shift_En);
      n_chk++;
      if (hot > 1) begin
        n_fail++;
        $display("FAIL onehot cyc=%0d got=%0d want<=1",
                 cyc, hot);
      end
    end
  end

  initial begin
    // reset, then idle
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 1);
    // load request in idle
    step(0, 1, 0, 1);
    repeat (2) step(0, 0, 0, 1);
    // M=1 multiply
    step(1, 0, 1, 1);
    repeat (2 * N + 3) step(0, 0, 1, 1);
    // M=0 multiply
    step(1, 0, 0, 1);
    repeat (2 * N + 3) step(0, 0, 0, 1);
    // Run held through completion plus 5
    repeat (2 * N + 7) step(1, 0, 1'($urandom), 1);
    step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    repeat (2 * N + 3) step(0, 0, 1'($urandom), 1);
    // reset in 3rd SHIFT, load request while busy
    step(1, 0, 1, 1);
    repeat (3) step(0, 1, 1, 1);
    repeat (2) step(0, 0, 1, 1);
    step(0, 1, 0, 1);
    step(0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 1);
    // randomised traffic
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 3) == 0),
           1'($urandom),
           1'($urandom_range(0, 63) != 0));
    end
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
